// File: rtl/seq3_rx_checker_pkg.sv
// Shared definitions for the 3-phase sequence receiver: state and symbol encodings,
// the phase successor function and the hex-digit segment table.
package seq3_rx_checker_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOCK = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [1:0] PH0    = 2'b00;
  localparam logic [1:0] PH1    = 2'b01;
  localparam logic [1:0] PH2    = 2'b10;
  localparam logic [1:0] PH_BAD = 2'b11;

  // Segments a..g in bits 0..6, active-high; index is the hex digit value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [7:0] IO_OUT_RESET = 8'h3F;

  // The illegal symbol maps to itself so it can never be a valid successor of a legal one.
  function automatic logic [1:0] succ(input logic [1:0] s);
    logic [1:0] r;
    case (s)
      PH0:     r = PH1;
      PH1:     r = PH2;
      PH2:     r = PH0;
      default: r = PH_BAD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq3_rx_checker_if.sv
// Standard 8-in/8-out user-module pin frame; io_in[0] carries the clock.
interface seq3_rx_checker_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/seq3_rx_checker_seg7_hex_decoder.sv
// Combinational hex digit to 7-segment decoder (a..g in bits 0..6, active-high).
module seg7_hex_decoder
  import seq3_rx_checker_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  logic [6:0] pattern;

  assign pattern = SEG_TABLE[digit];

  for (genvar gi = 0; gi < 7; gi++) begin : g_seg
    assign seg[gi] = pattern[gi];
  end

endmodule

// File: rtl/seq3_rx_checker.sv
// Receiver/checker for the 00->01->10 phase sequence: hunts for lock, counts cycles and
// sequence errors, and shows one counter on a registered 7-segment digit plus a lock LED.
module seq3_rx_checker
  import seq3_rx_checker_pkg::*;
#(
  parameter int HUNT_GOOD = 2,
  parameter int CNT_W     = 4
) (
  seq3_rx_checker_if.slave pins
);

  logic       clk;
  logic       srst;
  logic       en;
  logic [1:0] sym;
  logic       dsel;
  logic       clr;
  logic       unused_pins;

  assign clk         = pins.io_in[0];
  assign srst        = pins.io_in[1];
  assign en          = pins.io_in[2];
  assign sym         = {pins.io_in[3], pins.io_in[4]};
  assign dsel        = pins.io_in[5];
  assign clr         = pins.io_in[6];
  assign unused_pins = pins.io_in[7];

  state_t           state_reg, state_next;
  logic [1:0]       prev_reg, prev_next;
  logic             prev_valid_reg, prev_valid_next;
  logic [1:0]       hunt_cnt_reg, hunt_cnt_next;
  logic [CNT_W-1:0] cyc_cnt_reg, cyc_cnt_next;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic [7:0]       io_out_reg, io_out_next;

  logic [2:0]       hunt_inc;
  logic             sym_ok;
  logic [CNT_W-1:0] digit;
  logic [6:0]       seg;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg      <= HUNT;
      prev_reg       <= PH0;
      prev_valid_reg <= 1'b0;
      hunt_cnt_reg   <= 2'd0;
      cyc_cnt_reg    <= '0;
      err_cnt_reg    <= '0;
      io_out_reg     <= IO_OUT_RESET;
    end else begin
      state_reg      <= state_next;
      prev_reg       <= prev_next;
      prev_valid_reg <= prev_valid_next;
      hunt_cnt_reg   <= hunt_cnt_next;
      cyc_cnt_reg    <= cyc_cnt_next;
      err_cnt_reg    <= err_cnt_next;
      io_out_reg     <= io_out_next;
    end
  end

  assign hunt_inc = {1'b0, hunt_cnt_reg} + 3'd1;
  assign sym_ok   = (sym != PH_BAD) && (sym == succ(prev_reg));

  always_comb begin
    state_next      = state_reg;
    prev_next       = prev_reg;
    prev_valid_next = prev_valid_reg;
    hunt_cnt_next   = hunt_cnt_reg;
    cyc_cnt_next    = cyc_cnt_reg;
    err_cnt_next    = err_cnt_reg;

    if (clr) begin
      // clr discards the sample and outranks any count or error it would have caused.
      state_next      = HUNT;
      prev_valid_next = 1'b0;
      hunt_cnt_next   = 2'd0;
      cyc_cnt_next    = '0;
      err_cnt_next    = '0;
    end else if (en) begin
      case (state_reg)
        HUNT: begin
          if (sym == PH_BAD) begin
            prev_valid_next = 1'b0;
            hunt_cnt_next   = 2'd0;
          end else if (!prev_valid_reg) begin
            prev_next       = sym;
            prev_valid_next = 1'b1;
          end else if (sym_ok) begin
            prev_next = sym;
            if (hunt_inc == 3'(HUNT_GOOD)) begin
              state_next    = LOCK;
              hunt_cnt_next = 2'd0;
            end else begin
              hunt_cnt_next = hunt_inc[1:0];
            end
          end else begin
            prev_next     = sym;
            hunt_cnt_next = 2'd0;
          end
        end
        LOCK: begin
          if (sym_ok) begin
            prev_next = sym;
            if (prev_reg == PH2 && sym == PH0) begin
              cyc_cnt_next = cyc_cnt_reg + CNT_W'(1);
            end
          end else begin
            if (err_cnt_reg != '1) begin
              err_cnt_next = err_cnt_reg + CNT_W'(1);
            end
            prev_valid_next = 1'b0;
            state_next      = ERR;
          end
        end
        ERR: begin
          if (sym != PH_BAD) begin
            prev_next       = sym;
            prev_valid_next = 1'b1;
            hunt_cnt_next   = 2'd0;
            state_next      = HUNT;
          end
        end
        default: begin
          state_next      = HUNT;
          prev_valid_next = 1'b0;
          hunt_cnt_next   = 2'd0;
        end
      endcase
    end
  end

  // Display is built from the current registers, so it trails each update by one clock.
  always_comb begin
    digit       = dsel ? err_cnt_reg : cyc_cnt_reg;
    io_out_next = {(state_reg == LOCK), seg};
  end

  seg7_hex_decoder u_seg7 (
    .digit (digit),
    .seg   (seg)
  );

  assign pins.io_out = io_out_reg;

endmodule

// File: tb/tb_seq3_rx_checker.sv
// Directed bench for seq3_rx_checker: lock, cycle counting, errors, saturation, wrap, clr, reset.
module tb_seq3_rx_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] sym;
  logic       dsel;
  logic       clr;

  int n_assert = 0;
  int n_fail   = 0;

  seq3_rx_checker_if pins ();

  assign pins.io_in = {1'b0, clr, dsel, sym[0], sym[1], en, rst, clk};

  seq3_rx_checker #(.HUNT_GOOD(2), .CNT_W(4)) dut (
    .pins (pins)
  );

  always #5 clk = ~clk;

  task automatic step(input logic e, input logic [1:0] s, input logic ds, input logic c);
    en   = e;
    sym  = s;
    dsel = ds;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    n_assert++;
    assert (pins.io_out === exp) else begin
      n_fail++;
      $error("FAIL %s: io_out=%h expected=%h", tag, pins.io_out, exp);
    end
    $display("check %-18s io_out=%h expected=%h", tag, pins.io_out, exp);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sym = 2'b00; dsel = 1'b0; clr = 1'b0;
    step(0, 2'b00, 0, 0);
    step(0, 2'b00, 0, 0);
    check("reset", 8'h3F);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step(0, 2'($urandom_range(0, 3)), 0, 0);
      check("en_low_idle", 8'h3F);
    end

    // Acquire lock and count two cycles.
    step(1, 2'b00, 0, 0);
    step(1, 2'b01, 0, 0);
    step(1, 2'b10, 0, 0);
    check("lock_edge", 8'h3F);
    step(1, 2'b00, 0, 0);
    check("lock_led", 8'hBF);
    step(1, 2'b01, 0, 0);
    check("cyc_one", 8'h86);
    step(1, 2'b10, 0, 0);
    step(1, 2'b00, 0, 0);
    step(0, 2'b00, 0, 0);
    check("cyc_two", 8'hDB);

    // One more cycle, then a skip 00->10 forces ERR.
    step(1, 2'b01, 0, 0);
    step(1, 2'b10, 0, 0);
    step(1, 2'b00, 0, 0);
    step(1, 2'b10, 0, 0);
    check("skip_err_edge", 8'hCF);
    step(0, 2'b00, 1, 0);
    check("err_led_off", 8'h06);
    step(1, 2'b01, 1, 0);
    step(1, 2'b10, 1, 0);
    step(1, 2'b00, 1, 0);
    step(0, 2'b00, 1, 0);
    check("relock_err1", 8'h86);
    step(0, 2'b00, 0, 0);
    check("relock_no_cyc", 8'hCF);

    // Illegal symbol in LOCK, then 17 further lock/error episodes to saturate.
    step(1, 2'b11, 0, 0);
    step(0, 2'b00, 1, 0);
    check("bad_sym_err2", 8'h5B);
    for (int i = 0; i < 17; i++) begin
      step(1, 2'b00, 1, 0);
      step(1, 2'b01, 1, 0);
      step(1, 2'b10, 1, 0);
      step(1, 2'b11, 1, 0);
    end
    step(0, 2'b00, 1, 0);
    check("err_saturate", 8'h71);
    step(0, 2'b00, 0, 0);
    check("cyc_unaffected", 8'h4F);

    // Clear, relock and run 16 full cycles to wrap the cycle counter.
    step(1, 2'b00, 0, 1);
    step(0, 2'b00, 0, 0);
    check("clr_from_err", 8'h3F);
    step(1, 2'b00, 0, 0);
    step(1, 2'b01, 0, 0);
    step(1, 2'b10, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step(1, 2'b00, 0, 0);
      step(1, 2'b01, 0, 0);
      step(1, 2'b10, 0, 0);
    end
    step(0, 2'b00, 0, 0);
    check("cyc_fifteen", 8'hF1);
    step(1, 2'b00, 0, 0);
    step(1, 2'b01, 0, 0);
    step(1, 2'b10, 0, 0);
    step(0, 2'b00, 0, 0);
    check("cyc_wrap", 8'hBF);

    // clr coinciding with a mismatch in LOCK.
    step(1, 2'b00, 0, 0);
    step(1, 2'b01, 0, 0);
    step(0, 2'b00, 0, 0);
    check("pre_clr", 8'h86);
    step(1, 2'b11, 0, 1);
    check("clr_edge", 8'h86);
    step(0, 2'b00, 0, 0);
    check("clr_cyc_zero", 8'h3F);
    step(0, 2'b00, 1, 0);
    check("clr_no_err", 8'h3F);

    // Mid-operation reset (with clr also high), then one transition short of lock.
    step(1, 2'b00, 0, 0);
    step(1, 2'b01, 0, 0);
    step(1, 2'b10, 0, 0);
    step(0, 2'b00, 0, 0);
    check("lock_before_rst", 8'hBF);
    rst = 1'b1;
    step(1, 2'b01, 0, 1);
    check("reset_mid_op", 8'h3F);
    rst = 1'b0;
    step(1, 2'b00, 0, 0);
    step(1, 2'b01, 0, 0);
    step(0, 2'b00, 0, 0);
    check("hunt_one_short", 8'h3F);
    step(1, 2'b10, 0, 0);
    step(0, 2'b00, 0, 0);
    check("lock_after_rst", 8'hBF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
